// File: rtl/avalon_rr_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_rr_arbiter
//
// Shares one Avalon-MM slave port between two masters using per-transfer
// round-robin arbitration. A registered grant state machine
// (IDLE / GRANT0 / GRANT1) owns the slave. The granted master's request is
// passed combinationally to the slave. The last-served master has the
// lowest priority on a tie, and m0 wins the first tie after reset.
//
// Handshake: a master request (read or write) is held until its waitrequest
// is low. A transfer completes on the first cycle where the granted master
// is requesting and s_waitrequest is low. Readdata is valid only in that
// cycle.
//
// Optional feature macro: ARB_LOCK_EN
//   defined   - when the granted master has mN_lock high at completion, it
//               keeps the grant, and `last` is not updated.
//   undefined - the m0_lock and m1_lock inputs are ignored.
//
// Ports:
//   Clk, Reset                       clock; synchronous active-high reset
//   mN_address/read/write/writedata/byteenable/lock   master N request
//   mN_readdata, mN_waitrequest      master N response
//   s_address/read/write/writedata/byteenable         shared slave request
//   s_readdata, s_waitrequest        shared slave response
//   grant                            one-hot owner (01 m0, 10 m1, 00 idle)
//   dbg_state                        grant FSM state (0 idle, 1 m0, 2 m1)
// -----------------------------------------------------------------------------
module avalon_rr_arbiter #(
    parameter int AW = 25,
    parameter int DW = 32
) (
    input  logic            Clk,
    input  logic            Reset,

    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    input  logic            m0_lock,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_waitrequest,

    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    input  logic            m1_lock,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_waitrequest,

    output logic [AW-1:0]   s_address,
    output logic            s_read,
    output logic            s_write,
    output logic [DW-1:0]   s_writedata,
    output logic [DW/8-1:0] s_byteenable,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_waitrequest,

    output logic [1:0]      grant,
    output logic [1:0]      dbg_state
);

    // The state encoding matches the grant encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // 0 = m0 served last, 1 = m1 served last

    logic req0, req1;
    logic lock0, lock1;

`ifdef ARB_LOCK_EN
    assign lock0 = m0_lock;
    assign lock1 = m1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
    logic unused_lock;
    assign unused_lock = m0_lock | m1_lock;
`endif

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Round-robin pick: on a tie, the master that was not served last wins.
    function automatic state_t arbitrate(input logic r0, input logic r1,
                                         input logic last);
        state_t nxt;
        nxt = ST_IDLE;
        if (r0 && r1)
            nxt = last ? ST_GRANT0 : ST_GRANT1;
        else if (r0)
            nxt = ST_GRANT0;
        else if (r1)
            nxt = ST_GRANT1;
        return nxt;
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: state_d = arbitrate(req0, req1, last_q);
            ST_GRANT0: begin
                if (!req0) begin
                    // The owner withdrew before completing, so release the grant.
                    state_d = arbitrate(req0, req1, last_q);
                end else if (!s_waitrequest) begin
                    if (lock0) begin
                        state_d = ST_GRANT0;
                    end else begin
                        last_d  = 1'b0;
                        state_d = arbitrate(req0, req1, 1'b0);
                    end
                end
            end
            ST_GRANT1: begin
                if (!req1) begin
                    state_d = arbitrate(req0, req1, last_q);
                end else if (!s_waitrequest) begin
                    if (lock1) begin
                        state_d = ST_GRANT1;
                    end else begin
                        last_d  = 1'b1;
                        state_d = arbitrate(req0, req1, 1'b1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slave-side multiplexing. A write takes precedence over a read that is
    // asserted in the same cycle.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        grant        = 2'b00;
        case (state_q)
            ST_GRANT0: begin
                s_address    = m0_address;
                s_read       = m0_read & ~m0_write;
                s_write      = m0_write;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
                grant        = 2'b01;
            end
            ST_GRANT1: begin
                s_address    = m1_address;
                s_read       = m1_read & ~m1_write;
                s_write      = m1_write;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
                grant        = 2'b10;
            end
            default: ;
        endcase
    end

    // Reset masks completion, so a transfer aborted by reset is never
    // acknowledged to a master.
    assign m0_waitrequest = ~((state_q == ST_GRANT0) & ~s_waitrequest & ~Reset);
    assign m1_waitrequest = ~((state_q == ST_GRANT1) & ~s_waitrequest & ~Reset);

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign dbg_state   = state_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
module tb_avalon_rr_arbiter;

    localparam int AW = 25;
    localparam int DW = 32;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [AW-1:0]   m0_address, m1_address;
    logic            m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0]   m0_writedata, m1_writedata;
    logic [DW/8-1:0] m0_byteenable, m1_byteenable;
    logic            m0_lock, m1_lock;
    logic [DW-1:0]   m0_readdata, m1_readdata;
    logic            m0_waitrequest, m1_waitrequest;
    logic [AW-1:0]   s_address;
    logic            s_read, s_write;
    logic [DW-1:0]   s_writedata;
    logic [DW/8-1:0] s_byteenable;
    logic [DW-1:0]   s_readdata;
    logic            s_waitrequest;
    logic [1:0]      grant;
    logic [1:0]      dbg_state;

    avalon_rr_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Reset(Reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_lock(m0_lock), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_lock(m1_lock), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entry: {grant, write, address, writedata}
    logic [59:0] exp_q[$];
    logic [59:0] exp_e;
    logic [1:0]  own [6];

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [59:0] pack(input logic [1:0] g, input logic w,
                                         input logic [24:0] a,
                                         input logic [31:0] d);
        return {g, w, a, d};
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m0_byteenable = 4'hf; m0_lock = 0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
        m1_byteenable = 4'hf; m1_lock = 0;
        s_readdata = '0; s_waitrequest = 0;
    endtask

    task automatic do_reset();
        idle_masters();
        Reset = 1;
        step();
        @(negedge Clk);
        check_eq("rst_grant", grant, 2'b00);
        check_eq("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        check_eq("rst_state", dbg_state, 2'd0);
        check_eq("rst_sbus", {s_read, s_write, s_address, s_writedata, s_byteenable}, '0);
        step();
        Reset = 0;
    endtask

    // Slave monitor: every completed slave transfer must match the head of
    // the queue.
    always @(negedge Clk) begin
        if (!Reset && (s_read || s_write) && !s_waitrequest) begin
            check_eq("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check_eq("sb_xfer", pack(grant, s_write, s_address, s_writedata), exp_e);
            end
        end
    end

    initial begin
        // Reset then idle for 10 cycles
        do_reset();
        repeat (10) begin
            @(negedge Clk);
            check_eq("idle_grant", grant, 2'b00);
            check_eq("idle_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
            check_eq("idle_strobe", {s_read, s_write}, 2'b00);
            step();
        end

        // m0 read, slave inserts 2 wait cycles
        do_reset();
        m0_address = 25'h100; m0_read = 1; s_waitrequest = 1;
        exp_q.push_back(pack(2'b01, 1'b0, 25'h100, 32'h0));
        @(negedge Clk);
        check_eq("rd_req_grant", grant, 2'b00);
        check_eq("rd_req_wait", m0_waitrequest, 1'b1);
        step();
        @(negedge Clk);
        check_eq("rd_grant", grant, 2'b01);
        check_eq("rd_sread", {s_read, s_write}, 2'b10);
        check_eq("rd_wait1", m0_waitrequest, 1'b1);
        step();
        @(negedge Clk);
        check_eq("rd_wait2", m0_waitrequest, 1'b1);
        step();
        s_waitrequest = 0; s_readdata = 32'hDEADBEEF;
        @(negedge Clk);
        check_eq("rd_done_wait", m0_waitrequest, 1'b0);
        check_eq("rd_m1_wait", m1_waitrequest, 1'b1);
        check_eq("rd_data", m0_readdata, 32'hDEADBEEF);
        step();
        m0_read = 0;
        @(negedge Clk);
        check_eq("rd_after_sread", s_read, 1'b0);
        step();
        @(negedge Clk);
        check_eq("rd_idle_grant", grant, 2'b00);

        // Both masters write continuously, zero-wait slave
        do_reset();
        m0_write = 1; m0_address = 25'h10; m0_writedata = 32'h1;
        m1_write = 1; m1_address = 25'h20; m1_writedata = 32'h2;
        for (int i = 0; i < 6; i++)
            exp_q.push_back((i % 2 == 0) ? pack(2'b01, 1'b1, 25'h10, 32'h1)
                                         : pack(2'b10, 1'b1, 25'h20, 32'h2));
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge Clk);
            check_eq("b2b_grant", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        step();
        m0_write = 0; m1_write = 0;
        step(); step();

        // m1 alone back-to-back, m0 joins mid-sequence
        do_reset();
        m1_write = 1; m1_address = 25'h30; m1_writedata = 32'h11;
        exp_q.push_back(pack(2'b10, 1'b1, 25'h30, 32'h11));
        exp_q.push_back(pack(2'b10, 1'b1, 25'h30, 32'h22));
        exp_q.push_back(pack(2'b01, 1'b1, 25'h40, 32'h77));
        exp_q.push_back(pack(2'b10, 1'b1, 25'h30, 32'h33));
        step();
        @(negedge Clk);
        check_eq("m1seq_g1", grant, 2'b10);
        step();
        m1_writedata = 32'h22;
        m0_write = 1; m0_address = 25'h40; m0_writedata = 32'h77;
        @(negedge Clk);
        check_eq("m1seq_g2", grant, 2'b10);
        check_eq("m1seq_m0wait", m0_waitrequest, 1'b1);
        step();
        m1_writedata = 32'h33;
        @(negedge Clk);
        check_eq("m1seq_g3", grant, 2'b01);
        check_eq("m1seq_m1wait", m1_waitrequest, 1'b1);
        step();
        m0_write = 0;
        @(negedge Clk);
        check_eq("m1seq_g4", grant, 2'b10);
        step();
        m1_write = 0;
        step(); step();
        @(negedge Clk);
        check_eq("m1seq_idle", grant, 2'b00);

        // Reset during GRANT1 with the slave stalled
        do_reset();
        s_waitrequest = 1;
        m1_write = 1; m1_address = 25'h60; m1_writedata = 32'h6;
        step();
        @(negedge Clk);
        check_eq("rst_g1_grant", grant, 2'b10);
        check_eq("rst_g1_swrite", s_write, 1'b1);
        check_eq("rst_g1_wait", m1_waitrequest, 1'b1);
        step();
        Reset = 1;
        @(negedge Clk);
        check_eq("rst_mid_wait", m1_waitrequest, 1'b1);
        step();
        Reset = 0;
        m0_write = 1; m0_address = 25'h50; m0_writedata = 32'h5;
        s_waitrequest = 0;
        @(negedge Clk);
        check_eq("rst_abort_grant", grant, 2'b00);
        check_eq("rst_abort_swrite", s_write, 1'b0);
        exp_q.push_back(pack(2'b01, 1'b1, 25'h50, 32'h5));
        exp_q.push_back(pack(2'b10, 1'b1, 25'h60, 32'h6));
        step();
        @(negedge Clk);
        check_eq("rst_tie_grant", grant, 2'b01);
        step();
        m0_write = 0;
        @(negedge Clk);
        check_eq("rst_next_grant", grant, 2'b10);
        step();
        m1_write = 0;
        step(); step();

        // m0 holds lock for 4 transfers while m1 requests
`ifdef ARB_LOCK_EN
        own = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`else
        own = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        do_reset();
        m0_write = 1; m0_address = 25'h70; m0_writedata = 32'hA0; m0_lock = 1;
        m1_write = 1; m1_address = 25'h80; m1_writedata = 32'hB0;
        for (int i = 0; i < 6; i++)
            exp_q.push_back((own[i] == 2'b01) ? pack(2'b01, 1'b1, 25'h70, 32'hA0)
                                              : pack(2'b10, 1'b1, 25'h80, 32'hB0));
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) m0_lock = 0;
            @(negedge Clk);
            check_eq("lock_grant", grant, own[i]);
        end
        step();
        m0_write = 0; m1_write = 0;
        step(); step();
        @(negedge Clk);
        check_eq("final_idle", grant, 2'b00);

        check_eq("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
